// File: rtl/mult_div_unit_if.sv
// ============================================================================
// Module      : mult_div_unit_if
// Description : Request/result bundle for the multiply/divide unit.
//               master = pipeline side, slave = mult_div_unit.
//   start      launch request (sampled only when idle)
//   op[1:0]    00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b[31:0] rs / rt operands
//   mthi, mtlo direct write of a into HI / LO
//   busy       high while an operation is in flight
//   done       one-cycle pulse when HI/LO take a new result
//   hi, lo     architectural HI/LO registers
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mult_div_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, mthi, mtlo,
                  input  busy, done, hi, lo);
  modport slave  (input  start, op, a, b, mthi, mtlo,
                  output busy, done, hi, lo);
endinterface

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module      : mult_div_unit
// Description : MIPS-style HI/LO multiply/divide unit. Radix-2 iterative
//               datapath (shift-add multiply, restoring divide) with a fixed
//               33-cycle latency for every op and operand value.
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    mult_div_unit_if.slave (start/op/a/b/mthi/mtlo in,
//          busy/done/hi/lo out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit (
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam logic [5:0] C_LAST_STEP = 6'd31;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_cnt;
  logic        r_is_div;
  logic [31:0] r_acc;     // product high half / partial remainder
  logic [31:0] r_sh;      // multiplier / dividend shifting into quotient
  logic [31:0] r_opnd;    // multiplicand / divisor magnitude
  logic        r_neg_q;   // negate product or quotient
  logic        r_neg_r;   // negate remainder (dividend sign)
  logic        r_dz;      // divide by zero
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;

  // Operand magnitudes: signed ops are op[0]==0
  logic        w_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_new_div;

  assign w_signed  = ~bus.op[0];
  assign w_new_div = bus.op[1];
  assign w_a_neg   = w_signed & bus.a[31];
  assign w_b_neg   = w_signed & bus.b[31];
  assign w_a_mag   = w_a_neg ? (32'd0 - bus.a) : bus.a;
  assign w_b_mag   = w_b_neg ? (32'd0 - bus.b) : bus.b;

  // Multiply step: add multiplicand when multiplier LSB set, then shift
  // the 65-bit {carry, acc, sh} right by one.
  logic [32:0] w_madd;
  assign w_madd = {1'b0, r_acc} + (r_sh[0] ? {1'b0, r_opnd} : 33'd0);

  // Restoring divide step. The partial remainder is always below the
  // divisor, so the accepted difference always fits in 32 bits and the
  // modulo-2^32 subtraction is exact.
  logic [32:0] w_shl;
  logic        w_ge;
  logic [31:0] w_sub;
  assign w_shl = {r_acc, r_sh[31]};
  assign w_ge  = (w_shl >= {1'b0, r_opnd});
  assign w_sub = w_shl[31:0] - r_opnd;

  // Sign correction applied in FIX
  logic [63:0] w_prod;
  logic [63:0] w_prod_s;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  assign w_prod   = {r_acc, r_sh};
  assign w_prod_s = r_neg_q ? (64'd0 - w_prod) : w_prod;
  // Divide by zero leaves all-ones quotient; force it past the sign fix.
  // The remainder naturally ends as |a|, which re-signs back to a.
  assign w_quo    = r_dz ? 32'hFFFF_FFFF : (r_neg_q ? (32'd0 - r_sh) : r_sh);
  assign w_rem    = r_neg_r ? (32'd0 - r_acc) : r_acc;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_CALC;
      S_CALC:  if (r_cnt == C_LAST_STEP) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- Datapath ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= 6'd0;
      r_is_div <= 1'b0;
      r_acc    <= 32'd0;
      r_sh     <= 32'd0;
      r_opnd   <= 32'd0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_cnt    <= 6'd0;
            r_is_div <= w_new_div;
            r_acc    <= 32'd0;
            r_sh     <= w_new_div ? w_a_mag : w_b_mag;
            r_opnd   <= w_new_div ? w_b_mag : w_a_mag;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_dz     <= (bus.b == 32'd0);
          end else begin
            if (bus.mthi) r_hi <= bus.a;
            if (bus.mtlo) r_lo <= bus.a;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 6'd1;
          if (r_is_div) begin
            r_acc <= w_ge ? w_sub : w_shl[31:0];
            r_sh  <= {r_sh[30:0], w_ge};
          end else begin
            r_acc <= w_madd[32:1];
            r_sh  <= {w_madd[0], r_sh[31:1]};
          end
        end
        S_FIX: begin
          r_done <= 1'b1;
          if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            r_hi <= w_prod_s[63:32];
            r_lo <= w_prod_s[31:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Self-checking bench for mult_div_unit: directed corner cases
//               plus random ops against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mult_div_unit_if bus ();

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic. longint division truncates toward
  // zero and % takes the dividend's sign; 0x80000000/-1 fits in 64 bits.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    longint      sx;
    longint      sy;
    longint      q;
    longint      rm;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r  = 64'd0;
    case (o)
      2'd0: r = 64'(sx * sy);
      2'd1: r = {32'd0, x} * {32'd0, y};
      default: begin
        if (y == 32'd0) begin
          r = {x, 32'hFFFF_FFFF};
        end else if (o == 2'd2) begin
          q  = sx / sy;
          rm = sx % sy;
          r  = {rm[31:0], q[31:0]};
        end else begin
          r = {x % y, x / y};
        end
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 50));
      default: return $urandom;
    endcase
  endfunction

  // mode 0: plain; 1: extra start pulses at busy cycles 5/10 plus mtlo at 10;
  // 2: mthi+mtlo raised together with start (start must win).
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int mode, input string tag);
    logic [63:0] exp;
    logic [31:0] hi0;
    logic [31:0] lo0;
    int          n;
    int          early_done;
    int          hold_bad;
    exp        = model(o, x, y);
    hi0        = bus.hi;
    lo0        = bus.lo;
    bus.op     = o;
    bus.a      = x;
    bus.b      = y;
    bus.start  = 1'b1;
    bus.mthi   = (mode == 2);
    bus.mtlo   = (mode == 2);
    @(posedge clk); #1;
    // operands scrambled after launch: they need not stay stable
    bus.start  = 1'b0;
    bus.mthi   = 1'b0;
    bus.mtlo   = 1'b0;
    bus.op     = 2'($urandom);
    bus.a      = $urandom;
    bus.b      = $urandom;
    n          = 0;
    early_done = 0;
    hold_bad   = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      if (bus.done !== 1'b0) early_done++;
      if (bus.hi !== hi0 || bus.lo !== lo0) hold_bad++;
      bus.start = 1'b0;
      bus.mtlo  = 1'b0;
      if (mode == 1 && (n == 5 || n == 10)) begin
        bus.start = 1'b1;
        bus.op    = 2'd1;
        bus.a     = 32'h0000_1234;
        bus.b     = 32'h0000_0003;
        if (n == 10) bus.mtlo = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    bus.mtlo  = 1'b0;
    chk({tag, " busy_width"}, 64'(n), 64'd33);
    chk({tag, " no_early_done"}, 64'(early_done), 64'd0);
    chk({tag, " hilo_hold"}, 64'(hold_bad), 64'd0);
    chk({tag, " done_pulse"}, {63'd0, bus.done}, 64'd1);
    chk({tag, " result"}, {bus.hi, bus.lo}, exp);
    @(posedge clk); #1;
    chk({tag, " done_drop"}, {63'd0, bus.done}, 64'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'd0;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("reset_state", {28'd0, bus.busy, bus.done, 2'd0, bus.hi}, 64'd0);
    chk("reset_lo", {32'd0, bus.lo}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // directed corner cases
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max");
    run_op(2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 0, "mult_neg");
    run_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 0, "div_neg");
    run_op(2'd3, 32'h0000_0007, 32'h0000_0000, 0, "divu_zero");
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    run_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0000, 0, "div_zero_neg");
    run_op(2'd2, 32'h8000_0000, 32'h0000_0000, 0, "div_zero_min");
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 0, "mult_min");
    run_op(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1, "start_ignored");
    run_op(2'd0, 32'h0000_0005, 32'hFFFF_FFFF, 2, "start_wins");

    // mtlo after done writes LO without a done pulse
    bus.a    = 32'h0000_1234;
    bus.mtlo = 1'b1;
    @(posedge clk); #1;
    bus.mtlo = 1'b0;
    chk("mtlo_lo", {32'd0, bus.lo}, 64'h1234);
    chk("mtlo_no_done", {62'd0, bus.done, bus.busy}, 64'd0);

    // mthi+mtlo together
    bus.a    = 32'hCAFE_BABE;
    bus.mthi = 1'b1;
    bus.mtlo = 1'b1;
    @(posedge clk); #1;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    chk("mthilo", {bus.hi, bus.lo}, 64'hCAFE_BABE_CAFE_BABE);
    chk("mthilo_no_done", {63'd0, bus.done}, 64'd0);

    // reset in the middle of a divide
    bus.op    = 2'd2;
    bus.a     = 32'd100;
    bus.b     = 32'd3;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("abort_flags", {62'd0, bus.busy, bus.done}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_idle", {62'd0, bus.busy, bus.done}, 64'd0);
    run_op(2'd2, 32'd100, 32'd3, 0, "rerun_div");

    // random ops of each kind against the reference model
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 150; i++) begin
        run_op(2'(k), pick(), pick(), 0, "random");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
